// File: rtl/instr_fetch_pkg.sv
// Shared core-wide definitions for the fetch stage.
//   fetch_state_t : fetch FSM state encoding (IDLE/REQ/HOLD/DRAIN)
//   ADDR_W_DEF    : default PC / instruction-memory address width
//   DATA_W_DEF    : default instruction width
//   NOP_INSTR     : instruction word treated as a no-op by the core
package instr_fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [DATA_W_DEF-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage of the multicycle core.
// Takes the committed PC, runs a req/ack transaction to instruction memory
// and holds the returned word in ir until decode accepts it.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   pc, fetch_start    : address to fetch and its start pulse
//   flush              : discard in-flight or held instruction
//   imem_req/addr      : memory request (held until ack) and address
//   imem_ack/rdata     : memory response
//   ir, ir_pc, ir_npc  : instruction, its address, and address+1 (to PCin)
//   ir_valid/ir_ready  : handshake with decode
//   busy               : FSM not idle
//   fetch_count        : instructions handed to decode (wrapping)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_start,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic [ADDR_W-1:0] ir_npc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_t      state, state_n;
  logic              req_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] ir_n;
  logic [ADDR_W-1:0] ir_pc_n;
  logic [ADDR_W-1:0] ir_npc_n;
  logic              valid_n;
  logic [CNT_W-1:0]  count_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      ir          <= '0;
      ir_pc       <= '0;
      ir_npc      <= '0;
      ir_valid    <= 1'b0;
      busy        <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      imem_req    <= req_n;
      imem_addr   <= addr_n;
      ir          <= ir_n;
      ir_pc       <= ir_pc_n;
      ir_npc      <= ir_npc_n;
      ir_valid    <= valid_n;
      busy        <= (state_n != IDLE);
      fetch_count <= count_n;
    end
  end

  always_comb begin
    state_n  = state;
    req_n    = imem_req;
    addr_n   = imem_addr;
    ir_n     = ir;
    ir_pc_n  = ir_pc;
    ir_npc_n = ir_npc;
    valid_n  = ir_valid;
    count_n  = fetch_count;

    unique case (state)
      IDLE: begin
        if (flush) begin
          valid_n = 1'b0;
        end else if (fetch_start) begin
          state_n = REQ;
          addr_n  = pc;
          req_n   = 1'b1;
        end
      end

      REQ: begin
        if (flush) begin
          // The request cannot be withdrawn: without an ack yet, wait it
          // out in DRAIN; with a coincident ack, just drop the data.
          if (imem_ack) begin
            state_n = IDLE;
            req_n   = 1'b0;
          end else begin
            state_n = DRAIN;
          end
        end else if (imem_ack) begin
          state_n  = HOLD;
          ir_n     = imem_rdata;
          ir_pc_n  = imem_addr;
          ir_npc_n = imem_addr + ADDR_W'(1);
          req_n    = 1'b0;
          valid_n  = 1'b1;
        end
      end

      HOLD: begin
        if (flush) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end else if (ir_ready) begin
          count_n = fetch_count + CNT_W'(1);
          valid_n = 1'b0;
          if (fetch_start) begin
            state_n = REQ;
            addr_n  = pc;
            req_n   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end

      DRAIN: begin
        if (imem_ack) begin
          state_n = IDLE;
          req_n   = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_start;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [31:0] ir_npc;
  logic        ir_valid;
  logic        ir_ready;
  logic        busy;
  logic [15:0] fetch_count;

  // Narrow-counter instance sharing all inputs, used to exercise counter wrap.
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_ir;
  logic [31:0] w_ir_pc;
  logic [31:0] w_ir_npc;
  logic        w_valid;
  logic        w_busy;
  logic [3:0]  w_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_start(fetch_start), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .ir_pc(ir_pc), .ir_npc(ir_npc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .busy(busy),
    .fetch_count(fetch_count)
  );

  instr_fetch #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) u_wrap (
    .clk(clk), .rst(rst), .pc(pc), .fetch_start(fetch_start), .flush(flush),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(w_ir), .ir_pc(w_ir_pc), .ir_npc(w_ir_npc),
    .ir_valid(w_valid), .ir_ready(ir_ready), .busy(w_busy),
    .fetch_count(w_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pc = '0; fetch_start = 1'b0; flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_ir", ir, 0);
    chk("rst_irpc", ir_pc, 0);
    chk("rst_irnpc", ir_npc, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fetch_count, 0);

    // Reset held two cycles mid-REQ, with an ack during reset.
    pc = 32'h5; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("r2_req", imem_req, 1);
    chk("r2_busy", busy, 1);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234;
    step();
    imem_ack = 1'b0;
    step();
    rst = 1'b0;
    chk("r2_req0", imem_req, 0);
    chk("r2_addr0", imem_addr, 0);
    chk("r2_busy0", busy, 0);
    chk("r2_ir0", ir, 0);
    imem_ack = 1'b1;   // late ack must be ignored
    step();
    imem_ack = 1'b0;
    step();
    chk("r2_novalid", ir_valid, 0);
    chk("r2_idle", busy, 0);

    // Zero-wait fetch.
    pc = 32'h10; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("zw_req1", imem_req, 1);
    chk("zw_addr", imem_addr, 32'h10);
    chk("zw_valid1", ir_valid, 0);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    step();
    imem_ack = 1'b0;
    chk("zw_req2", imem_req, 0);
    chk("zw_valid2", ir_valid, 1);
    chk("zw_ir", ir, 32'hDEADBEEF);
    chk("zw_irpc", ir_pc, 32'h10);
    chk("zw_irnpc", ir_npc, 32'h11);
    chk("zw_cnt0", fetch_count, 0);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    chk("zw_valid3", ir_valid, 0);
    chk("zw_cnt1", fetch_count, 1);
    chk("zw_busy3", busy, 0);

    // Wait states: ack on the 4th request cycle, fetch_start ignored in REQ.
    pc = 32'h40; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", imem_req, 1);
      chk("ws_addr", imem_addr, 32'h40);
      chk("ws_valid", ir_valid, 0);
      pc = 32'h99;
      fetch_start = (i == 1);
      step();
      fetch_start = 1'b0;
    end
    chk("ws_req4", imem_req, 1);
    chk("ws_addr4", imem_addr, 32'h40);
    imem_ack = 1'b1; imem_rdata = 32'hA5A50001;
    step();
    imem_ack = 1'b0;
    chk("ws_valid", ir_valid, 1);
    chk("ws_ir", ir, 32'hA5A50001);
    chk("ws_irpc", ir_pc, 32'h40);
    chk("ws_req0", imem_req, 0);

    // Stall in HOLD for 5 cycles, fetch_start without ir_ready ignored.
    for (int i = 0; i < 5; i++) begin
      pc = 32'h77;
      fetch_start = (i == 2);
      step();
      fetch_start = 1'b0;
      chk("st_valid", ir_valid, 1);
      chk("st_ir", ir, 32'hA5A50001);
      chk("st_irpc", ir_pc, 32'h40);
      chk("st_req", imem_req, 0);
    end

    // Back-to-back: consume and start next fetch in the same cycle.
    ir_ready = 1'b1; fetch_start = 1'b1; pc = 32'h20;
    step();
    ir_ready = 1'b0; fetch_start = 1'b0;
    chk("bb_req", imem_req, 1);
    chk("bb_addr", imem_addr, 32'h20);
    chk("bb_valid", ir_valid, 0);
    chk("bb_cnt", fetch_count, 2);
    chk("bb_busy", busy, 1);
    imem_ack = 1'b1; imem_rdata = 32'h22222222;
    step();
    imem_ack = 1'b0;
    chk("bb_valid2", ir_valid, 1);
    chk("bb_irpc", ir_pc, 32'h20);

    // Flush in HOLD.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fh_valid", ir_valid, 0);
    chk("fh_busy", busy, 0);
    chk("fh_cnt", fetch_count, 2);
    chk("fh_ir", ir, 32'h22222222);

    // Flush in REQ before ack -> DRAIN until ack.
    pc = 32'h30; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("fr_req", imem_req, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fr_req_d1", imem_req, 1);
    chk("fr_busy_d1", busy, 1);
    chk("fr_valid_d1", ir_valid, 0);
    fetch_start = 1'b1; pc = 32'h55;   // ignored in DRAIN
    step();
    fetch_start = 1'b0;
    chk("fr_req_d2", imem_req, 1);
    chk("fr_addr_d2", imem_addr, 32'h30);
    chk("fr_valid_d2", ir_valid, 0);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0BAD0;
    step();
    imem_ack = 1'b0;
    chk("fr_req0", imem_req, 0);
    chk("fr_busy0", busy, 0);
    chk("fr_valid0", ir_valid, 0);
    chk("fr_cnt", fetch_count, 2);
    chk("fr_ir", ir, 32'h22222222);
    step();
    chk("fr_idle", busy, 0);
    chk("fr_novalid", ir_valid, 0);

    // Flush coinciding with ack in REQ.
    pc = 32'h31; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    flush = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0BADF00D;
    step();
    flush = 1'b0; imem_ack = 1'b0;
    chk("fa_busy", busy, 0);
    chk("fa_req", imem_req, 0);
    chk("fa_valid", ir_valid, 0);
    chk("fa_ir", ir, 32'h22222222);

    // PC wrap.
    pc = 32'hFFFFFFFF; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h1;
    step();
    imem_ack = 1'b0;
    chk("pw_irpc", ir_pc, 32'hFFFFFFFF);
    chk("pw_irnpc", ir_npc, 32'h0);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    chk("pw_cnt", fetch_count, 3);
    chk("pw_wcnt", w_count, 3);

    // Counter wrap on the 4-bit instance: 12 fetches -> 15, one more -> 0.
    for (int i = 0; i < 13; i++) begin
      pc = 32'h100 + i; fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'hC0DE0000 + i;
      step();
      imem_ack = 1'b0;
      chk("cw_irpc", ir_pc, 32'h100 + i);
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      if (i == 11) chk("cw_w15", w_count, 4'hF);
    end
    chk("cw_w0", w_count, 0);
    chk("cw_cnt16", fetch_count, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the multicycle RISC core. Sits directly downstream of the PC update stage.
- Takes the committed PC and runs a req/ack transaction to instruction memory. Holds the returned word in an instruction register for decode.
- Supplies the instruction's PC and its sequential successor (PC+1, word addressing); the successor feeds back as the PC stage's PCin.

Parameters:
ADDR_W, 32, PC / instruction-memory address width (word addressed)
DATA_W, 32, instruction width
CNT_W, 16, width of retired-fetch counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
pc  in  ADDR_W  committed PC from PC update stage
fetch_start  in  1  pulse: fetch instruction at pc
flush  in  1  discard any in-flight or held instruction
imem_req  out  1  memory request, held until imem_ack
imem_addr  out  ADDR_W  request address, stable while imem_req=1
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  DATA_W  instruction word, valid with imem_ack
ir  out  DATA_W  instruction register
ir_pc  out  ADDR_W  address ir was fetched from
ir_npc  out  ADDR_W  ir_pc+1, to PCin of PC update stage
ir_valid  out  1  ir holds an unconsumed instruction
ir_ready  in  1  decode accepts ir this cycle
busy  out  1  state != IDLE
fetch_count  out  CNT_W  instructions handed to decode

Behaviour:
- Reset: state IDLE; ir, ir_pc, ir_npc, imem_addr, fetch_count = 0; imem_req, ir_valid, busy = 0. Reset in any state aborts the transaction the next edge; a late ack is ignored.
- All outputs are registered.
- States: IDLE, REQ, HOLD, DRAIN.
- Priority: rst > flush > normal transitions.
- IDLE:
  - fetch_start=1 -> REQ; imem_addr<=pc, imem_req<=1.
  - Otherwise stay.
- REQ:
  - imem_req held high, imem_addr held constant.
  - imem_ack=1 -> HOLD; ir<=imem_rdata, ir_pc<=imem_addr, ir_npc<=imem_addr+1 (mod 2^ADDR_W), imem_req<=0, ir_valid<=1.
  - fetch_start ignored.
- HOLD:
  - ir, ir_pc, ir_npc stable while ir_valid=1 and ir_ready=0.
  - ir_ready=1 -> fetch_count<=fetch_count+1 (wraps at 2^CNT_W), ir_valid<=0.
  - Next state: REQ if fetch_start is also 1 (imem_addr<=pc, imem_req<=1, back-to-back); otherwise IDLE.
  - fetch_start without ir_ready is ignored.
- flush:
  - IDLE or HOLD -> IDLE; ir_valid<=0; fetch_count unchanged; ir contents retained but invalid.
  - REQ with imem_ack=0 -> DRAIN. imem_req stays high (handshake never withdrawn).
  - REQ with imem_ack=1 in the same cycle -> IDLE, data discarded, imem_req<=0.
- DRAIN:
  - Waits for imem_ack, discards imem_rdata, then imem_req<=0 -> IDLE.
  - ir_valid never asserts. fetch_start and flush ignored.
- Latency: fetch_start at cycle 0 -> imem_req=1 at cycle 1. Ack at cycle k (k>=1) -> ir_valid=1 at cycle k+1. Zero-wait memory gives 2 cycles.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Shared package (core-wide): state encoding localparams (IDLE=2'd0, REQ=2'd1, HOLD=2'd2, DRAIN=2'd3), ADDR_W/DATA_W defaults, NOP instruction constant.
- No sub-module; a single FSM plus datapath registers, roughly 150 lines.

Test Plan:
- Reset: hold rst 2 cycles mid-REQ with imem_ack pulsed during reset -> all outputs 0, state IDLE, no ir_valid afterwards.
- Zero-wait: pc=0x10, fetch_start c0, imem_ack=1 c1 with rdata 0xDEADBEEF, ir_ready=1 -> imem_req high c1 only, ir_valid c2, ir=0xDEADBEEF, ir_pc=0x10, ir_npc=0x11, fetch_count=1 at c3.
- Wait states: ack 3 cycles after req -> imem_req high 4 cycles with imem_addr constant; ir_valid one cycle after ack; fetch_start pulses during REQ ignored.
- Stall and back-to-back: ir_ready=0 for 5 cycles in HOLD -> ir/ir_pc stable. Then ir_ready=1 with fetch_start, pc=0x20 -> imem_req=1, imem_addr=0x20 next cycle; fetch_count increments by 1.
- Flush: flush in REQ before ack -> DRAIN, imem_req stays high; ack 2 cycles later -> IDLE, ir_valid never 1, fetch_count unchanged. Flush in HOLD -> ir_valid 0 next cycle.
- Wrap: pc=0xFFFFFFFF fetched -> ir_npc=0x00000000. fetch_count preloaded to 0xFFFF, then one consumed fetch -> fetch_count=0.
